// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - CPU-side and main-memory-side signal bundle for dcache_ctrl
//
// Purpose: groups the load/store access signals from EX/MEM and the word-serial
// main-memory handshake into one bundle.
//   slave  : the cache controller (consumes CPU access and memory responses)
//   master : the environment (CPU pipeline plus main memory)
// Signals:
//   cpu_read, cpu_write, cpu_addr[31:0], cpu_wdata[31:0]  access from EX/MEM
//   cpu_rdata[31:0], mem_stall_req                        results to pipeline / hazard unit
//   mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0]      word request to main memory
//   mem_rdata[31:0], mem_ack                              word response from main memory
interface dcache_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mem_stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, mem_stall_req, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, mem_stall_req, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache with miss FSM
//
// Purpose: MEM-stage data cache. Hits complete with no stall; a miss raises
// mem_stall_req, optionally writes the dirty victim line back word by word, then
// refills the line word by word and lets the held access retry as a hit.
// Parameters: INDEX_BITS (2^INDEX_BITS lines), WORDS_PER_LINE (power of two, >= 2).
// Ports:
//   clk             single clock, rising edge
//   rst_n           synchronous active-low reset
//   bus             dcache_ctrl_if.slave (CPU access + main-memory handshake)
//   hit_count[31:0] / miss_count[31:0]  only when DCACHE_STATS_EN is defined
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters).
module dcache_ctrl #(
    parameter int INDEX_BITS     = 6,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS = 32 - INDEX_BITS - OFF_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                state, state_next;
    logic [OFF_BITS-1:0]   cnt, cnt_next;

    logic [31:0]           data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]      valid;
    logic [LINES-1:0]      dirty;

    logic [OFF_BITS-1:0]   req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  access;
    logic                  hit;
    logic                  last_word;
    logic                  unused_addr_bits;

    logic                  idle_hit;
    logic                  idle_miss;
    logic                  hit_write;
    logic                  fill_we;
    logic                  fill_done;

    assign req_off          = bus.cpu_addr[OFF_BITS+1:2];
    assign req_idx          = bus.cpu_addr[OFF_BITS+2 +: INDEX_BITS];
    assign req_tag          = bus.cpu_addr[31 -: TAG_BITS];
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    assign access    = bus.cpu_read | bus.cpu_write;
    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign last_word = &cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        bus.mem_stall_req = 1'b0;
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.cpu_rdata     = '0;
        idle_hit          = 1'b0;
        idle_miss         = 1'b0;
        hit_write         = 1'b0;
        fill_we           = 1'b0;
        fill_done         = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        idle_hit      = 1'b1;
                        hit_write     = bus.cpu_write;
                        bus.cpu_rdata = data_mem[{req_idx, req_off}];
                    end else begin
                        idle_miss         = 1'b1;
                        bus.mem_stall_req = 1'b1;
                        cnt_next          = '0;
                        state_next        = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.mem_stall_req = 1'b1;
                bus.mem_req       = 1'b1;
                bus.mem_we        = 1'b1;
                bus.mem_addr      = {tag_mem[req_idx], req_idx, cnt, 2'b00};
                bus.mem_wdata     = data_mem[{req_idx, cnt}];
                if (bus.mem_ack) begin
                    // the counter wraps to zero on the last word, ready for the refill
                    cnt_next = cnt + 1'b1;
                    if (last_word) begin
                        state_next = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                bus.mem_stall_req = 1'b1;
                bus.mem_req       = 1'b1;
                bus.mem_addr      = {req_tag, req_idx, cnt, 2'b00};
                if (bus.mem_ack) begin
                    fill_we  = 1'b1;
                    cnt_next = cnt + 1'b1;
                    if (last_word) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Valid is set only once the whole line has arrived, so an aborted refill
    // leaves the line invalid even though some data words were overwritten.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (hit_write) begin
                dirty[req_idx] <= 1'b1;
            end
            if (fill_done) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (hit_write) begin
                data_mem[{req_idx, req_off}] <= bus.cpu_wdata;
            end
            if (fill_we) begin
                data_mem[{req_idx, cnt}] <= bus.mem_rdata;
            end
            if (fill_done) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit seen in the cycle right after a refill is the stalled access
    // retrying; it was already counted as a miss.
    logic retry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            retry      <= 1'b0;
        end else begin
            retry <= fill_done;
            if (idle_hit && !retry) begin
                hit_count <= hit_count + 32'd1;
            end
            if (idle_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized self-checking bench for dcache_ctrl against a line-level cache model
module tb_dcache_ctrl;
    localparam int IB    = 6;
    localparam int WPL   = 4;
    localparam int LINES = 1 << IB;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        ack;
    } txn_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(
        .INDEX_BITS     (IB),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdata  [LINES][WPL];
    logic [31:0] mtag   [LINES];
    bit          mvalid [LINES];
    bit          mdirty [LINES];
    logic [31:0] mm [logic [31:0]];
    int          m_hits   = 0;
    int          m_misses = 0;

    int   wait_mode = 0;
    bit   waited    = 0;
    int   waits     = 0;
    txn_t log_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mm_read(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Main-memory responder: decides ack for the coming edge, logs every request cycle.
    // mem_ack is also pulsed randomly while no request is pending; the cache must ignore it.
    always @(negedge clk) begin : responder
        bit do_ack;
        if (bus.mem_req) begin
            case (wait_mode)
                0:       do_ack = 1'b1;
                1:       begin do_ack = waited; waited = !waited; end
                default: do_ack = ($urandom_range(0, 1) == 1);
            endcase
            log_q.push_back('{bus.mem_addr, bus.mem_we, bus.mem_wdata, do_ack});
            if (!do_ack) waits++;
            bus.mem_ack   = do_ack;
            bus.mem_rdata = (do_ack && !bus.mem_we) ? mm_read(bus.mem_addr) : $urandom;
        end else begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
        end
    end

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int mode, output int stall_o);
        logic [31:0] word, off, idx, tag, rdata_obs;
        bit          hit, done;
        int          base, stall, j;
        exp_t        exp_q [$];

        word = addr >> 2;
        off  = word % WPL;
        idx  = (word / WPL) % LINES;
        tag  = word / (WPL * LINES);
        hit  = mvalid[idx] && (mtag[idx] == tag);
        base = 0;
        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            base = 1 + WPL;
            if (mvalid[idx] && mdirty[idx]) begin
                base += WPL;
                for (int w = 0; w < WPL; w++)
                    exp_q.push_back('{((mtag[idx] * LINES + idx) * WPL + w) * 4, 1'b1, mdata[idx][w]});
            end
            for (int w = 0; w < WPL; w++)
                exp_q.push_back('{((tag * LINES + idx) * WPL + w) * 4, 1'b0, 32'h0});
        end

        @(posedge clk);
        #1;
        wait_mode     = mode;
        waited        = 0;
        waits         = 0;
        log_q.delete();
        bus.cpu_write = wr;
        bus.cpu_read  = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.cpu_addr  = addr | {30'h0, 2'($urandom_range(0, 3))};
        bus.cpu_wdata = wdata;

        stall = 0;
        done  = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!bus.mem_stall_req) begin
                done = 1;
                break;
            end
            stall++;
        end
        check("stall_timeout", 32'(done), 32'd1);
        rdata_obs = bus.cpu_rdata;
        check("idle_mem_req", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;

        check("stall_cycles", stall, base + waits);
        check("txn_count", log_q.size(), exp_q.size() + waits);
        j = 0;
        foreach (log_q[k]) begin
            if (j >= exp_q.size()) begin
                check("txn_extra", 32'd1, 32'd0);
                break;
            end
            check("txn_addr", log_q[k].addr, exp_q[j].addr);
            check("txn_we", 32'(log_q[k].we), 32'(exp_q[j].we));
            if (exp_q[j].we) check("txn_wdata", log_q[k].wdata, exp_q[j].wdata);
            if (log_q[k].ack) j++;
        end

        if (!hit) begin
            if (mvalid[idx] && mdirty[idx])
                for (int w = 0; w < WPL; w++)
                    mm[((mtag[idx] * LINES + idx) * WPL + w) * 4] = mdata[idx][w];
            for (int w = 0; w < WPL; w++)
                mdata[idx][w] = mm_read(((tag * LINES + idx) * WPL + w) * 4);
            mvalid[idx] = 1;
            mdirty[idx] = 0;
            mtag[idx]   = tag;
        end
        if (wr) begin
            mdata[idx][off] = wdata;
            mdirty[idx]     = 1;
        end else begin
            check("rdata", rdata_obs, mdata[idx][off]);
        end
        stall_o = stall;
    endtask

    initial begin
        int st;
        logic [31:0] a;
        int idx_set [5] = '{0, 1, 4, 16, 63};

        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        for (int w = 0; w < WPL; w++) mm[32'h40 + 4 * w] = 32'hA0 + w;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_stall", 32'(bus.mem_stall_req), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);

        access(0, 32'h40, 0, 0, st);
        check("tp_clean_miss_stall", st, 5);
        access(0, 32'h48, 0, 0, st);
        check("tp_hit_stall", st, 0);
        check("tp_hit_data", mdata[4][2], 32'hA2);
`ifdef DCACHE_STATS_EN
        check("stats_miss_first", miss_count, 32'd1);
        check("stats_hit_first", hit_count, 32'd1);
`endif
        access(1, 32'h44, 32'hDEADBEEF, 0, st);
        check("tp_store_hit_stall", st, 0);
        access(0, 32'h444, 0, 0, st);
        check("tp_dirty_miss_stall", st, 9);
        access(0, 32'h800, 0, 1, st);
        check("tp_wait_refill_stall", st, 9);
        access(1, 32'h100, 32'hCAFE0100, 0, st);
        access(0, 32'h100, 0, 0, st);
        check("tp_store_miss_reread", st, 0);
        access(0, 32'h2100, 0, 0, st);
        check("tp_store_miss_wb_stall", st, 9);

        // reset asserted at the second refill ack
        @(posedge clk);
        #1;
        wait_mode    = 0;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h1050;
        @(negedge clk);
        check("midrst_miss_stall", 32'(bus.mem_stall_req), 32'd1);
        @(negedge clk);
        check("midrst_alloc_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("midrst_mem_addr", bus.mem_addr, 32'd0);
        check("midrst_held_miss", 32'(bus.mem_stall_req), 32'd1);
        bus.cpu_read = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
        m_hits   = 0;
        m_misses = 0;
        access(0, 32'h1050, 0, 0, st);
        check("midrst_reread_misses", st, 5);

        for (int r = 0; r < 250; r++) begin
            a = ((32'($urandom_range(0, 3)) * LINES + 32'(idx_set[$urandom_range(0, 4)])) * WPL
                 + 32'($urandom_range(0, WPL - 1))) * 4;
            access($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 2), st);
        end

`ifdef DCACHE_STATS_EN
        check("stats_hit_total", hit_count, 32'(m_hits));
        check("stats_miss_total", miss_count, 32'(m_misses));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache with miss FSM, in the MEM stage of the 5-stage MIPS pipeline. It services loads and stores from EX/MEM and raises `mem_stall_req` to the hazard unit on a miss. While stalled, the hazard unit freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Line refill and dirty write-back use a word-serial request/ack handshake to main memory.

## Interface
- `INDEX_BITS`, 6: number of lines is 2^INDEX_BITS.
- `WORDS_PER_LINE`, 4: words per line; power of two, minimum 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `cpu_read`  in  1  load access this cycle.
- `cpu_write`  in  1  store access this cycle.
- `cpu_addr`  in  32  byte address; bits [1:0] ignored (word accesses only).
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data; valid when hit and `mem_stall_req`=0.
- `mem_stall_req`  out  1  to hazard unit; high while the access cannot complete.
- `mem_req`  out  1  main-memory word request.
- `mem_we`  out  1  1 = write-back word, 0 = refill read.
- `mem_addr`  out  32  word-aligned main-memory address.
- `mem_wdata`  out  32  write-back data.
- `mem_rdata`  in  32  refill data, valid with `mem_ack`.
- `mem_ack`  in  1  one word transferred this cycle.

## Operation
- Address split: word offset = [log2(WPL)+1:2]; index = next INDEX_BITS bits; tag = remaining upper bits.
- Per line: valid bit, dirty bit, tag, WPL data words.
- `cpu_write` takes priority if both `cpu_read` and `cpu_write` are high. No access: `mem_stall_req`=0, no state change.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, hit (valid and tag match):
  - `mem_stall_req`=0.
  - Read: `cpu_rdata` = addressed word, combinational.
  - Write: word written and dirty set at the clock edge.
- IDLE, miss:
  - `mem_stall_req`=1, combinational, same cycle.
  - Next state WRITEBACK if the victim is valid and dirty, else ALLOCATE.
  - Word counter cleared.
- WRITEBACK:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr` = {victim tag, index, counter, 2'b00}; `mem_wdata` = victim word[counter].
  - Each `mem_ack` increments the counter. After the last ack: clear counter, go to ALLOCATE.
- ALLOCATE:
  - `mem_req`=1, `mem_we`=0, `mem_addr` = {request tag, index, counter, 2'b00}.
  - Each `mem_ack` writes `mem_rdata` into word[counter].
  - Last ack: set tag, valid=1, dirty=0, go to IDLE.
- After refill, IDLE re-evaluates the still-held access as a hit. A store then merges and sets dirty.
- `mem_stall_req`=1 in every WRITEBACK/ALLOCATE cycle.
- `mem_ack` while `mem_req`=0 is ignored.
- CPU inputs must stay stable while stalled; the hazard unit guarantees this. Values are sampled only in IDLE.

## Timing
- Reset values (rst_n=0 at an edge):
  - State = IDLE; counter = 0; all valid and dirty bits = 0. Data and tag arrays are not reset.
  - Outputs the cycle after the reset edge: `mem_req`=0, `mem_we`=0, `mem_stall_req`=0 unless an access is present (it then misses), `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=0 when no hit.
- Reset mid-operation: abort at once and return to IDLE; `mem_req` drops the next cycle; partial line discarded (valid stays 0).
- Hit latency: 0 stall cycles.
- Clean miss, ack every cycle: stall high for 1 + WPL cycles; data returned in cycle 2 + WPL.
- Dirty miss: stall high for 1 + 2·WPL cycles, plus any memory wait cycles (`mem_req` high, `mem_ack` low).
- Counter width is log2(WPL) and wraps to 0 on the last word.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds `hit_count` (out, 32) and `miss_count` (out, 32), reset to 0, wrapping.
  - `miss_count` +1 on each IDLE miss detection.
  - `hit_count` +1 on each IDLE hit that is not the retry immediately following a refill.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then read 0x0000_0040: stall high for 5 cycles with mem_rdata 0xA0..0xA3 on back-to-back acks at 0x40,0x44,0x48,0x4C; cpu_rdata=0xA0 in cycle 6; a following read of 0x0000_0048 hits with 0 stall and returns 0xA2.
- Write 0xDEADBEEF to 0x0000_0044 after that fill: no stall. Then read 0x0000_0444 (same index 4, different tag): 4 write-back words at 0x40..0x4C with word 1 = 0xDEADBEEF, then a 4-word refill from 0x440; stall high for 9 cycles.
- Refill with one wait cycle (mem_ack low) on every word: stall lasts 9 cycles and mem_addr holds during each wait.
- Store miss to a clean line at 0x0000_0100: refill, then a read of 0x100 returns the store data and the line is dirty (the next conflicting miss writes it back).
- rst_n low during the 2nd ALLOCATE ack: mem_req=0 the next cycle, state IDLE, and a re-read of the same address misses again.
- With DCACHE_STATS_EN: the first scenario yields miss_count=1 and hit_count=1 (the post-refill retry is not counted).
